// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter with hex readout.
// Segment patterns are active-low, ordered a..g from bit 6 down to bit 0.
package counter_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  function automatic logic [SEG_W-1:0] seg_lookup(input logic [3:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0001100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  function automatic int digit_count(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/hex_seg7.sv
// One hex digit decoder: nibble to active-low 7-segment pattern, with a
// blank override for leading-zero suppression.
module hex_seg7
  import counter_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = seg_lookup(nibble);
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/updown_counter_hex.sv
// Up/down modulo counter with load, clear and wrap pulse, driving one
// active-low 7-segment display per nibble of the registered count.
module updown_counter_hex
  import counter_pkg::*;
#(
  parameter int  WIDTH         = 8,
  parameter bit  BLANK_LEADING = 1'b0,
  localparam int DIGITS        = digit_count(WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   up_down,
  input  logic                   sclr,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_value,
  input  logic [WIDTH-1:0]       max_value,
  output logic [WIDTH-1:0]       count,
  output logic                   wrap,
  output logic [SEG_W*DIGITS-1:0] hex
);

  localparam int PAD_W = 4 * DIGITS;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // Up-wrap uses >= so a loaded value above max_value recovers in one step.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (sclr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable) begin
      if (up_down) begin
        if (count_q >= max_value) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = max_value;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

  logic [PAD_W-1:0]  count_pad;
  logic [DIGITS-1:0] blank;

  assign count_pad = PAD_W'(count_q);

  // blank[i] chains downward from the top digit; digit 0 always shows.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else if (i == DIGITS - 1) begin : g_msd
      assign blank[i] = BLANK_LEADING && (count_pad[4*i +: 4] == 4'h0);
    end else begin : g_mid
      assign blank[i] = BLANK_LEADING && (count_pad[4*i +: 4] == 4'h0) && blank[i+1];
    end

    hex_seg7 u_seg (
      .nibble (count_pad[4*i +: 4]),
      .blank  (blank[i]),
      .seg    (hex[SEG_W*i +: SEG_W])
    );
  end

endmodule

// File: tb/tb_updown_counter_hex.sv
// Scoreboard bench: 8-bit unblanked counter plus a 16-bit blanked readout.
module tb_updown_counter_hex;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, up_down, sclr, load;
  logic [7:0]  load_value, max_value;
  logic [7:0]  count8;
  logic        wrap8;
  logic [13:0] hex8;

  logic        load16;
  logic [15:0] load_value16;
  logic [15:0] count16;
  logic        wrap16;
  logic [27:0] hex16;

  typedef struct {
    logic [7:0]  c8;
    logic        w8;
    logic [13:0] h8;
    logic [15:0] c16;
    logic [27:0] h16;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] c16_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  updown_counter_hex #(.WIDTH(8), .BLANK_LEADING(1'b0)) dut8 (
    .clock(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .sclr(sclr), .load(load), .load_value(load_value), .max_value(max_value),
    .count(count8), .wrap(wrap8), .hex(hex8)
  );

  updown_counter_hex #(.WIDTH(16), .BLANK_LEADING(1'b1)) dut16 (
    .clock(clk), .reset(reset), .enable(1'b0), .up_down(1'b1),
    .sclr(1'b0), .load(load16), .load_value(load_value16), .max_value(16'hFFFF),
    .count(count16), .wrap(wrap16), .hex(hex16)
  );

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [13:0] hex8_exp(input logic [7:0] c);
    return {seg(c[7:4]), seg(c[3:0])};
  endfunction

  function automatic logic [27:0] hex16_exp(input logic [15:0] c);
    logic [27:0] h;
    logic        zero_above;
    zero_above = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      zero_above = zero_above && (c[4*i +: 4] == 4'h0);
      h[7*i +: 7] = (i > 0 && zero_above) ? 7'b1111111 : seg(c[4*i +: 4]);
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic l, input logic [7:0] lv,
                      input logic e, input logic ud, input logic [7:0] mv,
                      input logic [7:0] ec, input logic ew,
                      input logic l16 = 1'b0, input logic [15:0] lv16 = 16'h0);
    exp_t x;
    @(negedge clk);
    sclr = s; load = l; load_value = lv; enable = e; up_down = ud; max_value = mv;
    load16 = l16; load_value16 = lv16;
    if (l16) c16_exp = lv16;
    x.c8 = ec; x.w8 = ew; x.h8 = hex8_exp(ec);
    x.c16 = c16_exp; x.h16 = hex16_exp(c16_exp);
    sb.push_back(x);
  endtask

  // Monitor: one expected entry retires per clock edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("count8", 32'(count8), 32'(x.c8));
        check("wrap8",  32'(wrap8),  32'(x.w8));
        check("hex8",   32'(hex8),   32'(x.h8));
        check("count16", 32'(count16), 32'(x.c16));
        check("hex16",  32'(hex16),  32'(x.h16));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 0; up_down = 1; sclr = 0; load = 0;
    load_value = 0; max_value = 8'hFF; load16 = 0; load_value16 = 0;
    c16_exp = 16'h0;
    #1;
    check("rst_count8", 32'(count8), 32'h0);
    check("rst_wrap8",  32'(wrap8),  32'h0);
    check("rst_hex8",   32'(hex8),   32'({7'b0000001, 7'b0000001}));
    check("rst_hex16",  32'(hex16),  32'({7'h7F, 7'h7F, 7'h7F, 7'b0000001}));
    @(negedge clk);
    reset = 1'b1;

    // decade up count, wrap on 9 -> 0
    for (int i = 1; i <= 11; i++)
      step(0, 0, 8'h00, 1, 1, 8'd9, 8'(i % 10), (i == 10));

    // down wrap to max_value 0xC8
    step(0, 1, 8'h01, 0, 0, 8'hC8, 8'h01, 0);
    step(0, 0, 8'h00, 1, 0, 8'hC8, 8'h00, 0);
    step(0, 0, 8'h00, 1, 0, 8'hC8, 8'hC8, 1);
    step(0, 0, 8'h00, 1, 0, 8'hC8, 8'hC7, 0);

    // priority sclr > load > enable, and out-of-range recovery
    step(1, 1, 8'h55, 1, 1, 8'hC8, 8'h00, 0);
    step(0, 1, 8'hF0, 1, 1, 8'h10, 8'hF0, 0);
    step(0, 0, 8'h00, 1, 1, 8'h10, 8'h00, 1);

    // max_value = 0: stuck at 0, wrap every enabled cycle
    step(0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 1);
    step(0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 1);
    step(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 1);

    // above-max decrements normally; full-range modulo wrap
    step(0, 1, 8'hF0, 0, 0, 8'h10, 8'hF0, 0);
    step(0, 0, 8'h00, 1, 0, 8'h10, 8'hEF, 0);
    step(0, 1, 8'hFF, 0, 1, 8'hFF, 8'hFF, 0);
    step(0, 0, 8'h00, 1, 1, 8'hFF, 8'h00, 1);

    // hold at 0x5A while the 16-bit readout exercises blanking
    step(0, 1, 8'h5A, 0, 1, 8'hFF, 8'h5A, 0);
    step(0, 0, 8'h00, 0, 1, 8'hFF, 8'h5A, 0, 1'b1, 16'h0030);
    @(posedge clk);
    #2;
    check("blank_0030", 32'(hex16), 32'({7'h7F, 7'h7F, 7'b0000110, 7'b0000001}));
    step(0, 0, 8'h00, 0, 0, 8'hFF, 8'h5A, 0, 1'b1, 16'h0A05);
    step(0, 0, 8'h00, 0, 1, 8'hFF, 8'h5A, 0, 1'b1, 16'h0000);
    @(posedge clk);
    #2;
    check("blank_0000", 32'(hex16), 32'({7'h7F, 7'h7F, 7'h7F, 7'b0000001}));
    step(0, 0, 8'h00, 0, 1, 8'hFF, 8'h5A, 0);
    step(0, 0, 8'h00, 0, 1, 8'hFF, 8'h5A, 0);

    // asynchronous reset mid-cycle at 0x37
    step(0, 1, 8'h37, 0, 1, 8'hFF, 8'h37, 0, 1'b1, 16'h1234);
    @(posedge clk);
    #3;
    load = 0; load16 = 0; enable = 0;
    reset = 1'b0;
    c16_exp = 16'h0;
    #1;
    check("arst_count8", 32'(count8), 32'h0);
    check("arst_wrap8",  32'(wrap8),  32'h0);
    check("arst_hex8lo", 32'(hex8[6:0]), 32'(7'b0000001));
    check("arst_count16", 32'(count16), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 8'h00, 1, 1, 8'hFF, 8'h01, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter_hex.md
Name: updown_counter_hex

Overview:
Parametrised, synchronous up/down counter with programmable terminal value (modulus), parallel load, synchronous clear and wrap pulse. It drives a bank of active-low 7-segment hex displays, one per nibble of the count. It is the next-generation replacement for the fixed 8-bit T-flip-flop counter/display pair, used wherever a board-level counter with readout is needed: lab timers, event counters, debug tallies.

Parameters:
WIDTH, 8, counter width in bits (2..32)
DIGITS, (WIDTH+3)/4, number of hex displays; localparam derived from WIDTH, not overridable
BLANK_LEADING, 0, 1 = blank leading-zero digits (digit 0 never blanked)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low; clears all state
enable  input  1  count step qualifier
up_down  input  1  1 = count up, 0 = count down
sclr  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_value  input  WIDTH  value captured on load
max_value  input  WIDTH  terminal value; count range 0..max_value
count  output  WIDTH  registered count
wrap  output  1  registered one-cycle pulse on wrap-around
hex  output  7*DIGITS  segments; digit i in hex[7*i+6 : 7*i], bit 6 = seg a ... bit 0 = seg g, active-low

Behaviour:
- Reset: reset is asynchronous, active-low. While reset=0: count=0, wrap=0; hex shows "0" on digit 0, and on all digits when BLANK_LEADING=0.
- Priority per rising edge: sclr > load > enable > hold.
- sclr=1: count<=0, wrap<=0.
- load=1: count<=load_value unchanged, even if load_value > max_value; wrap<=0.
- enable=1, up_down=1:
  - if count >= max_value: count<=0, wrap<=1
  - else count<=count+1, wrap<=0
- enable=1, up_down=0:
  - if count==0: count<=max_value, wrap<=1
  - else count<=count-1, wrap<=0
  - Count above max_value decrements normally, no clamp.
- enable=0 (no sclr/load): count holds, wrap<=0.
- wrap is high exactly one cycle per wrap event. With continuous enable and a wrap every step (max_value=0), it stays high.
- max_value=0: count stays 0 in both directions; wrap=1 on every enabled cycle.
- max_value may change at any time; it takes effect on the next edge. No internal copy is kept.
- Arithmetic is modulo 2^WIDTH internally and unsigned only. Up-wrap uses >=, so an out-of-range count recovers to 0 in one step.
- Latency: count/wrap update 1 clock after the qualifying edge. hex is combinational from registered count, with no extra latency.
- Top nibble when WIDTH % 4 != 0: zero-extended before decode.
- Segment encoding (hex digit -> a..g, 0=lit):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0001100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
  - blank: 1111111
- BLANK_LEADING=1: digit i (i>0) is blank when it and all higher digits are 0.
- Reset asserted mid-count: immediate clear, independent of clock. Deassertion is expected synchronous to the clock at board level; no internal synchroniser.

Decomposition:
- Package counter_pkg: SEG_W=7, SEG_BLANK constant, 16-entry segment lookup constant/function, digit-count function.
- Sub-module hex_seg7: 4-bit nibble + blank input -> 7-bit active-low segments. Instantiated DIGITS times by generate.
- Counter core and leading-zero blanking chain live in the top module.

Test Plan:
1. Reset: assert reset=0 mid-count at count=0x37 -> count=0x00 and wrap=0 immediately, with no clock edge; hex[6:0]=0000001.
2. Decade up, WIDTH=8, max_value=9, up_down=1, enable=1 for 12 cycles -> count 0..9,0,1; wrap=1 only on the 9->0 cycle; hex[6:0] for 9 = 0001100.
3. Down wrap, max_value=0xC8, count=1, enable=1, up_down=0 -> 1,0,0xC8 with wrap pulse; then 0xC7; hex[13:7]=0110001 (C), hex[6:0]=0000000 (8).
4. Priority: same edge sclr=1, load=1, enable=1 -> count=0. Next edge load=1, load_value=0xF0, max_value=0x10, enable=1 up -> count=0xF0. Next enabled up step -> count=0, wrap=1.
5. Hold: enable=0 for 5 cycles at count=0x5A -> count stays 0x5A, wrap=0; hex shows 5,A.
6. Blanking: WIDTH=16, BLANK_LEADING=1, count=0x0030 -> digits 3,2 blank (1111111), digit 1=0000110, digit 0=0000001. Count=0 -> only digit 0 lit.
